// File: rtl/cpu_isa_pkg.sv
// Shared ISA constants for the multi-cycle CPU: opcodes, extender
// select codes and the field-decode FSM encoding.
package cpu_isa_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [1:0] EXT_IMM  = 2'b00;
    localparam logic [1:0] EXT_BR   = 2'b01;
    localparam logic [1:0] EXT_JMP  = 2'b10;
    localparam logic [1:0] EXT_NONE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_CAPTURE = 2'b01,
        ST_VALID   = 2'b10
    } fd_state_t;

endpackage

// File: rtl/opcode_classify.sv
// Maps a 6-bit opcode to the extender select and an illegal flag.
// Purely combinational so the control unit can reuse it.
module opcode_classify
    import cpu_isa_pkg::*;
(
    input  logic [5:0] i_opcode,
    output logic [1:0] o_ext_sel,
    output logic       o_illegal
);

    always_comb begin
        o_ext_sel = EXT_NONE;
        o_illegal = 1'b0;
        case (i_opcode)
            OP_RTYPE:                       o_ext_sel = EXT_NONE;
            OP_J, OP_JAL:                   o_ext_sel = EXT_JMP;
            OP_BEQ, OP_BNE:                 o_ext_sel = EXT_BR;
            OP_ADDI, OP_XORI, OP_LW, OP_SW: o_ext_sel = EXT_IMM;
            default: begin
                o_ext_sel = EXT_NONE;
                o_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_field_decode.sv
// Instruction register and field-decode stage: IR capture, registered
// field slices, extender select, and a valid/ack handoff to control.
module instr_field_decode
    import cpu_isa_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        ir_we,
    input  logic [31:0] instr_in,
    output logic        busy,
    output logic        fields_valid,
    input  logic        fields_ack,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] imm16,
    output logic [25:0] target26,
    output logic [1:0]  ext_sel,
    output logic        illegal
);

    fd_state_t   r_state;
    logic [31:0] r_ir;
    logic        r_busy;
    logic        r_valid;
    logic [5:0]  r_opcode;
    logic [4:0]  r_rs;
    logic [4:0]  r_rt;
    logic [4:0]  r_rd;
    logic [4:0]  r_shamt;
    logic [5:0]  r_funct;
    logic [15:0] r_imm16;
    logic [25:0] r_target26;
    logic [1:0]  r_ext_sel;
    logic        r_illegal;

    logic [1:0]  w_ext_sel;
    logic        w_illegal;

    opcode_classify u_classify (
        .i_opcode  (r_ir[31:26]),
        .o_ext_sel (w_ext_sel),
        .o_illegal (w_illegal)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_ir       <= '0;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
            r_opcode   <= '0;
            r_rs       <= '0;
            r_rt       <= '0;
            r_rd       <= '0;
            r_shamt    <= '0;
            r_funct    <= '0;
            r_imm16    <= '0;
            r_target26 <= '0;
            r_ext_sel  <= EXT_NONE;
            r_illegal  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (ir_we) begin
                        r_ir    <= instr_in;
                        r_busy  <= 1'b1;
                        r_state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    r_opcode   <= r_ir[31:26];
                    r_rs       <= r_ir[25:21];
                    r_rt       <= r_ir[20:16];
                    r_rd       <= r_ir[15:11];
                    r_shamt    <= r_ir[10:6];
                    r_funct    <= r_ir[5:0];
                    r_imm16    <= r_ir[15:0];
                    r_target26 <= r_ir[25:0];
                    r_ext_sel  <= w_ext_sel;
                    r_illegal  <= w_illegal;
                    r_state    <= ST_VALID;
                end
                ST_VALID: begin
                    // Ack wins over a concurrent ir_we; that word is dropped.
                    if (fields_ack) begin
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_valid <= 1'b1;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy         = r_busy;
    assign fields_valid = r_valid;
    assign opcode       = r_opcode;
    assign rs           = r_rs;
    assign rt           = r_rt;
    assign rd           = r_rd;
    assign shamt        = r_shamt;
    assign funct        = r_funct;
    assign imm16        = r_imm16;
    assign target26     = r_target26;
    assign ext_sel      = r_ext_sel;
    assign illegal      = r_illegal;

endmodule

// File: tb/tb_instr_field_decode.sv
// Directed-vector bench for instr_field_decode with hand-computed
// field values per instruction word.
module tb_instr_field_decode;

    logic        clk;
    logic        reset;
    logic        ir_we;
    logic [31:0] instr_in;
    logic        busy;
    logic        fields_valid;
    logic        fields_ack;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic [25:0] target26;
    logic [1:0]  ext_sel;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    instr_field_decode dut (
        .clk          (clk),
        .reset        (reset),
        .ir_we        (ir_we),
        .instr_in     (instr_in),
        .busy         (busy),
        .fields_valid (fields_valid),
        .fields_ack   (fields_ack),
        .opcode       (opcode),
        .rs           (rs),
        .rt           (rt),
        .rd           (rd),
        .shamt        (shamt),
        .funct        (funct),
        .imm16        (imm16),
        .target26     (target26),
        .ext_sel      (ext_sel),
        .illegal      (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load at edge N, then step to just after edge N+2.
    task automatic load_word(input logic [31:0] w);
        ir_we    = 1'b1;
        instr_in = w;
        tick();
        ir_we    = 1'b0;
        tick();
        tick();
    endtask

    task automatic do_ack();
        fields_ack = 1'b1;
        tick();
        fields_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        ir_we      = 1'b1;
        instr_in   = 32'h21280005;
        fields_ack = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b0;
        ir_we = 1'b0;
        tick();
        checks++;
        if ({opcode, rs, rt, rd, shamt, funct} !== 32'h0) begin
            errors++;
            $display("FAIL reset_fields got %h %h %h %h %h %h want 0",
                     opcode, rs, rt, rd, shamt, funct);
        end
        checks++;
        if (imm16 !== 16'h0 || target26 !== 26'h0) begin
            errors++;
            $display("FAIL reset_imm got imm16=%h t26=%h want 0", imm16, target26);
        end
        checks++;
        if (ext_sel !== 2'b11 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset_ext got ext=%b ill=%b want 11/0", ext_sel, illegal);
        end
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || fields_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_nocapture got busy=%b valid=%b want 0/0",
                     busy, fields_valid);
        end
    endtask

    task automatic test_addi();
        load_word(32'h21280005);
        checks++;
        if (fields_valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL addi_valid got valid=%b busy=%b want 1/1", fields_valid, busy);
        end
        checks++;
        if (opcode !== 6'h08 || rs !== 5'd9 || rt !== 5'd8 || imm16 !== 16'h0005) begin
            errors++;
            $display("FAIL addi_fields got op=%h rs=%0d rt=%0d imm=%h want 08/9/8/0005",
                     opcode, rs, rt, imm16);
        end
        checks++;
        if (ext_sel !== 2'b00 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL addi_ext got ext=%b ill=%b want 00/0", ext_sel, illegal);
        end
        do_ack();
        checks++;
        if (fields_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL addi_ack got valid=%b busy=%b want 0/0", fields_valid, busy);
        end
    endtask

    task automatic test_branch_jump();
        load_word(32'h1422FFFF);
        checks++;
        if (opcode !== 6'h05 || rs !== 5'd1 || rt !== 5'd2 || imm16 !== 16'hFFFF
            || ext_sel !== 2'b01 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL bne got op=%h rs=%0d rt=%0d imm=%h ext=%b ill=%b want 05/1/2/ffff/01/0",
                     opcode, rs, rt, imm16, ext_sel, illegal);
        end
        do_ack();
        load_word(32'h08000100);
        checks++;
        if (opcode !== 6'h02 || target26 !== 26'h0000100 || ext_sel !== 2'b10
            || fields_valid !== 1'b1) begin
            errors++;
            $display("FAIL jump got op=%h t26=%h ext=%b valid=%b want 02/0000100/10/1",
                     opcode, target26, ext_sel, fields_valid);
        end
        do_ack();
    endtask

    task automatic test_rtype_illegal();
        load_word(32'h00221820);
        checks++;
        if (opcode !== 6'h00 || rs !== 5'd1 || rt !== 5'd2 || rd !== 5'd3
            || shamt !== 5'd0 || funct !== 6'h20) begin
            errors++;
            $display("FAIL rtype_fields got op=%h rs=%0d rt=%0d rd=%0d sh=%0d fn=%h",
                     opcode, rs, rt, rd, shamt, funct);
        end
        checks++;
        if (ext_sel !== 2'b11 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL rtype_ext got ext=%b ill=%b want 11/0", ext_sel, illegal);
        end
        do_ack();
        load_word(32'hFC000000);
        checks++;
        if (opcode !== 6'h3F || illegal !== 1'b1 || ext_sel !== 2'b11) begin
            errors++;
            $display("FAIL illegal got op=%h ill=%b ext=%b want 3f/1/11",
                     opcode, illegal, ext_sel);
        end
        do_ack();
        load_word(32'h38000000);
        checks++;
        if (opcode !== 6'h0E || ext_sel !== 2'b00 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL xori got op=%h ext=%b ill=%b want 0e/00/0",
                     opcode, ext_sel, illegal);
        end
        do_ack();
        load_word(32'h0C000000);
        checks++;
        if (opcode !== 6'h03 || ext_sel !== 2'b10 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL jal got op=%h ext=%b ill=%b want 03/10/0",
                     opcode, ext_sel, illegal);
        end
        do_ack();
    endtask

    task automatic test_busy_drop();
        load_word(32'h00221820);
        for (int i = 0; i < 5; i++) begin
            ir_we    = (i == 2);
            instr_in = 32'h8C000000;
            tick();
        end
        ir_we = 1'b0;
        checks++;
        if (opcode !== 6'h00 || rd !== 5'd3 || fields_valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_hold got op=%h rd=%0d valid=%b busy=%b want 00/3/1/1",
                     opcode, rd, fields_valid, busy);
        end
        fields_ack = 1'b1;
        ir_we      = 1'b1;
        instr_in   = 32'h8C000000;
        tick();
        fields_ack = 1'b0;
        checks++;
        if (busy !== 1'b0 || fields_valid !== 1'b0) begin
            errors++;
            $display("FAIL ack_wins got busy=%b valid=%b want 0/0", busy, fields_valid);
        end
        tick();
        ir_we = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL reload_busy got busy=%b want 1", busy);
        end
        tick();
        tick();
        checks++;
        if (opcode !== 6'h23 || ext_sel !== 2'b00 || fields_valid !== 1'b1) begin
            errors++;
            $display("FAIL reload got op=%h ext=%b valid=%b want 23/00/1",
                     opcode, ext_sel, fields_valid);
        end
        do_ack();
    endtask

    task automatic test_reset_midop();
        ir_we    = 1'b1;
        instr_in = 32'h2B000004;
        tick();
        ir_we = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || opcode !== 6'h00 || ext_sel !== 2'b11) begin
            errors++;
            $display("FAIL rst_capture got busy=%b op=%h ext=%b want 0/00/11",
                     busy, opcode, ext_sel);
        end
        tick();
        tick();
        checks++;
        if (fields_valid !== 1'b0 || opcode !== 6'h00) begin
            errors++;
            $display("FAIL rst_capture_after got valid=%b op=%h want 0/00",
                     fields_valid, opcode);
        end
        ir_we    = 1'b1;
        instr_in = 32'hAC000004;
        tick();
        ir_we = 1'b0;
        tick();
        reset      = 1'b1;
        fields_ack = 1'b1;
        tick();
        reset      = 1'b0;
        fields_ack = 1'b0;
        checks++;
        if (busy !== 1'b0 || fields_valid !== 1'b0 || opcode !== 6'h00
            || imm16 !== 16'h0 || ext_sel !== 2'b11) begin
            errors++;
            $display("FAIL rst_valid got busy=%b valid=%b op=%h imm=%h ext=%b",
                     busy, fields_valid, opcode, imm16, ext_sel);
        end
        tick();
        tick();
        checks++;
        if (fields_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_valid_after got valid=%b busy=%b want 0/0",
                     fields_valid, busy);
        end
    endtask

    initial begin
        reset      = 1'b0;
        ir_we      = 1'b0;
        instr_in   = '0;
        fields_ack = 1'b0;
        test_reset();
        test_addi();
        test_branch_jump();
        test_rtype_illegal();
        test_busy_drop();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
